// File: rtl/alu_md_control_if.sv
// Bus between the EX-stage pipeline and alu_md_control: decode inputs, operands,
// and the ALU/multiply-divide outputs. md_state mirrors the sequencer state.
interface alu_md_control_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       ALUop;
    logic [5:0]       FuncCode;
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALUCtrl;
    logic             MDSel;
    logic [WIDTH-1:0] MDResult;
    logic             MDBusy;
    logic             Stall;
    logic             Done;
    logic             DivByZero;
    logic [WIDTH-1:0] HiOut;
    logic [WIDTH-1:0] LoOut;
    logic [1:0]       md_state;

    modport master (
        output ALUop, FuncCode, Start, A, B,
        input  ALUCtrl, MDSel, MDResult, MDBusy, Stall, Done, DivByZero,
        input  HiOut, LoOut, md_state
    );

    modport slave (
        input  ALUop, FuncCode, Start, A, B,
        output ALUCtrl, MDSel, MDResult, MDBusy, Stall, Done, DivByZero,
        output HiOut, LoOut, md_state
    );
endinterface

// File: rtl/alu_md_control.sv
// ALU control decode plus multi-cycle multiply/divide sequencer with HI/LO.
// Optional macro MD_EARLY_OUT_EN: multiply finishes once remaining multiplier bits are zero.
module alu_md_control #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic              CLK,
    input logic              Reset,
    alu_md_control_if.slave  bus
);
    // Handshake: Start is valid; an MD instruction is consumed on an edge with
    // Start && !Stall, i.e. ready is !MDBusy. Stalled instructions are re-presented.
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
    state_t state, state_nxt;

    logic [3:0]         alu_ctrl;
    logic               is_md;
    logic [WIDTH-1:0]   hi, lo;
    logic [2*WIDTH-1:0] acc, opa;
    logic [WIDTH-1:0]   opb;
    logic [CNT_W-1:0]   cnt;
    logic               neg_res, neg_rem, dz, is_mul, done, dbz;

    always_comb begin
        alu_ctrl = 4'bxxxx;
        is_md    = 1'b0;
        if (bus.ALUop != 4'b1111) begin
            alu_ctrl = bus.ALUop;
        end else begin
            case (bus.FuncCode)
                6'b000000: alu_ctrl = 4'b0011;
                6'b000010: alu_ctrl = 4'b0100;
                6'b000011: alu_ctrl = 4'b1101;
                6'b100000: alu_ctrl = 4'b0010;
                6'b100001: alu_ctrl = 4'b1000;
                6'b100010: alu_ctrl = 4'b0110;
                6'b100011: alu_ctrl = 4'b1001;
                6'b100100: alu_ctrl = 4'b0000;
                6'b100101: alu_ctrl = 4'b0001;
                6'b100110: alu_ctrl = 4'b1010;
                6'b100111: alu_ctrl = 4'b1100;
                6'b101010: alu_ctrl = 4'b0111;
                6'b101011: alu_ctrl = 4'b1011;
                F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                    alu_ctrl = 4'b0010;
                    is_md    = 1'b1;
                end
                default: alu_ctrl = 4'bxxxx;
            endcase
        end
    end

    logic is_mfhi, is_mflo, is_mthi, is_mtlo, is_mult, is_div;
    assign is_mfhi = is_md && (bus.FuncCode == F_MFHI);
    assign is_mflo = is_md && (bus.FuncCode == F_MFLO);
    assign is_mthi = is_md && (bus.FuncCode == F_MTHI);
    assign is_mtlo = is_md && (bus.FuncCode == F_MTLO);
    assign is_mult = is_md && (bus.FuncCode[5:1] == 5'b01100);
    assign is_div  = is_md && (bus.FuncCode[5:1] == 5'b01101);

    logic busy, issue, accept;
    assign busy   = (state != IDLE);
    assign issue  = is_md && bus.Start;
    assign accept = issue && !busy;

    // Signed forms (funct bit 0 clear) operate on magnitudes and fix the sign at the end.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign a_neg = !bus.FuncCode[0] && bus.A[WIDTH-1];
    assign b_neg = !bus.FuncCode[0] && bus.B[WIDTH-1];
    assign a_mag = a_neg ? -bus.A : bus.A;
    assign b_mag = b_neg ? -bus.B : bus.B;

    logic [2*WIDTH-1:0] acc_mul, acc_div, prod;
    logic [WIDTH:0]     rem_sh, rem_sub;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic               last_mul, last_cnt;

    assign acc_mul  = opb[0] ? acc + opa : acc;
    assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    assign rem_sub  = rem_sh - {1'b0, opb};
    assign acc_div  = (rem_sh >= {1'b0, opb}) ? {rem_sub[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                                              : {acc[2*WIDTH-2:0], 1'b0};
    assign prod     = neg_res ? -acc : acc;
    assign quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    assign last_cnt = (cnt == CNT_W'(1));
`ifdef MD_EARLY_OUT_EN
    assign last_mul = last_cnt || (opb[WIDTH-1:1] == '0);
`else
    assign last_mul = last_cnt;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && is_mult)     state_nxt = MUL;
                else if (accept && is_div) state_nxt = (bus.B == '0) ? FIX : DIV;
            end
            MUL:     if (last_mul) state_nxt = FIX;
            DIV:     if (last_cnt) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state   <= IDLE;
            hi      <= '0;
            lo      <= '0;
            acc     <= '0;
            opa     <= '0;
            opb     <= '0;
            cnt     <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dz      <= 1'b0;
            is_mul  <= 1'b0;
            done    <= 1'b0;
            dbz     <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            dbz   <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (is_mthi) hi <= bus.A;
                    if (is_mtlo) lo <= bus.A;
                    if (is_mult || is_div) begin
                        is_mul  <= is_mult;
                        cnt     <= CNT_W'(WIDTH);
                        opb     <= b_mag;
                        opa     <= {{WIDTH{1'b0}}, a_mag};
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        dz      <= 1'b0;
                        if (is_mult) begin
                            acc <= '0;
                        end else if (bus.B == '0) begin
                            // Preload the FIX result directly: HI = A, LO = all ones.
                            acc     <= {bus.A, {WIDTH{1'b1}}};
                            neg_res <= 1'b0;
                            neg_rem <= 1'b0;
                            dz      <= 1'b1;
                        end else begin
                            acc <= {{WIDTH{1'b0}}, a_mag};
                        end
                    end
                end
                MUL: begin
                    acc <= acc_mul;
                    opa <= opa << 1;
                    opb <= opb >> 1;
                    cnt <= cnt - CNT_W'(1);
                end
                DIV: begin
                    acc <= acc_div;
                    cnt <= cnt - CNT_W'(1);
                end
                FIX: begin
                    done <= 1'b1;
                    dbz  <= dz;
                    if (is_mul) begin
                        hi <= prod[2*WIDTH-1:WIDTH];
                        lo <= prod[WIDTH-1:0];
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ALUCtrl   = alu_ctrl;
    assign bus.MDSel     = bus.Start && (is_mfhi || is_mflo);
    assign bus.MDResult  = is_mfhi ? hi : (is_mflo ? lo : '0);
    assign bus.MDBusy    = busy;
    assign bus.Stall     = issue && busy;
    assign bus.Done      = done;
    assign bus.DivByZero = dbz;
    assign bus.HiOut     = hi;
    assign bus.LoOut     = lo;
    assign bus.md_state  = state;
endmodule
